// File: rtl/frame_seq_pkg.sv
// rtl/frame_seq_pkg.sv - shared types and constants for the frame buffer sequencer
package frame_seq_pkg;

    typedef enum logic [2:0] {
        LIVE       = 3'd0,
        REC        = 3'd1,
        REC_PAUSE  = 3'd2,
        PLAY       = 3'd3,
        PLAY_PAUSE = 3'd4
    } state_t;

    localparam int unsigned FRAME_WORDS     = 640 * 480 / 2;
    localparam int unsigned SLOT_STRIDE_DEF = 32'h40000;

endpackage

// File: rtl/frame_slot_ring.sv
// rtl/frame_slot_ring.sv - record slot ring: write slot, valid count, playback slot walk
module frame_slot_ring
    import frame_seq_pkg::*;
#(
    parameter  int NUM_SLOTS = 8,
    localparam int SLOT_W    = $clog2(NUM_SLOTS),
    localparam int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              commit_i,
    input  logic              set_oldest_i,
    input  logic              advance_i,
    output logic [SLOT_W-1:0] wr_slot_o,
    output logic [SLOT_W-1:0] wr_slot_next_o,
    output logic [CNT_W-1:0]  rec_count_o,
    output logic [SLOT_W-1:0] play_slot_o
);

    logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
    logic [SLOT_W-1:0] play_slot_q, play_slot_d;
    logic [CNT_W-1:0]  rec_count_q, rec_count_d;
    logic [SLOT_W-1:0] oldest, newest;
    logic              full;

    // Once the ring is full the write slot always points at the oldest frame.
    assign full   = (rec_count_q == CNT_W'(NUM_SLOTS));
    assign oldest = full ? wr_slot_q : '0;
    assign newest = wr_slot_q - SLOT_W'(1);

    always_comb begin
        wr_slot_d   = wr_slot_q;
        rec_count_d = rec_count_q;
        play_slot_d = play_slot_q;
        if (commit_i) begin
            wr_slot_d = wr_slot_q + SLOT_W'(1);
            if (!full) begin
                rec_count_d = rec_count_q + CNT_W'(1);
            end
        end
        if (set_oldest_i) begin
            play_slot_d = oldest;
        end else if (advance_i) begin
            play_slot_d = (play_slot_q == newest) ? oldest : play_slot_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_slot_q   <= '0;
            rec_count_q <= '0;
            play_slot_q <= '0;
        end else begin
            wr_slot_q   <= wr_slot_d;
            rec_count_q <= rec_count_d;
            play_slot_q <= play_slot_d;
        end
    end

    assign wr_slot_o      = wr_slot_q;
    assign wr_slot_next_o = wr_slot_d;
    assign rec_count_o    = rec_count_q;
    assign play_slot_o    = play_slot_q;

endmodule

// File: rtl/frame_seq_ctrl.sv
// rtl/frame_seq_ctrl.sv - record/playback sequencer for the SDRAM frame buffer ports
module frame_seq_ctrl
    import frame_seq_pkg::*;
#(
    parameter  int          NUM_SLOTS   = 8,
    parameter  int          ADDR_W      = 23,
    parameter  int unsigned SLOT_STRIDE = SLOT_STRIDE_DEF,
    parameter  int unsigned BASE_ADDR   = 0,
    parameter  int          DISP_HOLD   = 4,
    localparam int          SLOT_W      = $clog2(NUM_SLOTS),
    localparam int          CNT_W       = $clog2(NUM_SLOTS + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_key_rec,
    input  logic              i_key_play,
    input  logic              i_key_stop,
    input  logic              i_cap_frame_start,
    input  logic              i_disp_frame_start,
    output logic [2:0]        o_state,
    output logic [ADDR_W-1:0] o_wr_base,
    output logic              o_wr_load,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_rd_base,
    output logic              o_rd_load,
    output logic [CNT_W-1:0]  o_rec_count,
    output logic [SLOT_W-1:0] o_play_slot
);

    localparam int HOLD_W = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;
    localparam logic [ADDR_W-1:0] LIVE_ADDR = ADDR_W'(BASE_ADDR + NUM_SLOTS * SLOT_STRIDE);

    function automatic logic [ADDR_W-1:0] slot_addr(input logic [SLOT_W-1:0] s);
        return ADDR_W'(BASE_ADDR + 32'(s) * SLOT_STRIDE);
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d, rd_base_q, rd_base_d;
    logic              wr_load_q, wr_load_d, rd_load_q, rd_load_d;
    logic              wr_en_q, wr_en_d;
    logic              rec_frame_q, rec_frame_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              commit, set_oldest, advance;
    logic [SLOT_W-1:0] wr_slot, wr_slot_next, play_slot;
    logic [CNT_W-1:0]  rec_count;

    frame_slot_ring #(.NUM_SLOTS(NUM_SLOTS)) u_ring (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .commit_i       (commit),
        .set_oldest_i   (set_oldest),
        .advance_i      (advance),
        .wr_slot_o      (wr_slot),
        .wr_slot_next_o (wr_slot_next),
        .rec_count_o    (rec_count),
        .play_slot_o    (play_slot)
    );

    always_comb begin
        state_d     = state_q;
        wr_base_d   = wr_base_q;
        wr_load_d   = 1'b0;
        wr_en_d     = wr_en_q;
        rd_base_d   = rd_base_q;
        rd_load_d   = 1'b0;
        rec_frame_d = rec_frame_q;
        hold_d      = hold_q;
        commit      = 1'b0;
        set_oldest  = 1'b0;
        advance     = 1'b0;

        // Frame events see the state as it was before any key in the same cycle.
        if (i_cap_frame_start) begin
            commit = rec_frame_q;
            case (state_q)
                LIVE: begin
                    wr_base_d   = LIVE_ADDR;
                    wr_load_d   = 1'b1;
                    wr_en_d     = 1'b1;
                    rec_frame_d = 1'b0;
                end
                REC: begin
                    wr_base_d   = slot_addr(wr_slot_next);
                    wr_load_d   = 1'b1;
                    wr_en_d     = 1'b1;
                    rec_frame_d = 1'b1;
                end
                default: begin
                    wr_en_d     = 1'b0;
                    rec_frame_d = 1'b0;
                end
            endcase
        end

        if (i_disp_frame_start) begin
            rd_load_d = 1'b1;
            case (state_q)
                PLAY: begin
                    rd_base_d = slot_addr(play_slot);
                    if (hold_q == HOLD_W'(DISP_HOLD - 1)) begin
                        hold_d  = '0;
                        advance = 1'b1;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                PLAY_PAUSE: rd_base_d = slot_addr(play_slot);
                default:    rd_base_d = LIVE_ADDR;
            endcase
        end

        if (i_key_stop) begin
            state_d     = LIVE;
            wr_en_d     = 1'b0;
            rec_frame_d = 1'b0;
        end else if (i_key_rec) begin
            case (state_q)
                LIVE, REC_PAUSE: state_d = REC;
                REC:             state_d = REC_PAUSE;
                default:         state_d = state_q;
            endcase
        end else if (i_key_play) begin
            case (state_q)
                LIVE, REC_PAUSE: begin
                    if (rec_count != '0) begin
                        state_d    = PLAY;
                        set_oldest = 1'b1;
                        hold_d     = '0;
                    end
                end
                PLAY:       state_d = PLAY_PAUSE;
                PLAY_PAUSE: state_d = PLAY;
                default:    state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= LIVE;
            wr_base_q   <= LIVE_ADDR;
            wr_load_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_base_q   <= LIVE_ADDR;
            rd_load_q   <= 1'b0;
            rec_frame_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_base_q   <= wr_base_d;
            wr_load_q   <= wr_load_d;
            wr_en_q     <= wr_en_d;
            rd_base_q   <= rd_base_d;
            rd_load_q   <= rd_load_d;
            rec_frame_q <= rec_frame_d;
            hold_q      <= hold_d;
        end
    end

    assign o_state     = state_q;
    assign o_wr_base   = wr_base_q;
    assign o_wr_load   = wr_load_q;
    assign o_wr_en     = wr_en_q;
    assign o_rd_base   = rd_base_q;
    assign o_rd_load   = rd_load_q;
    assign o_rec_count = rec_count;
    assign o_play_slot = play_slot;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// tb/tb_frame_seq_ctrl.sv - scoreboard bench for frame_seq_ctrl against a behavioural model
module tb_frame_seq_ctrl;
    import frame_seq_pkg::*;

    localparam int N    = 8;
    localparam int HOLD = 4;
    localparam logic [22:0] LIVE_A = 23'h200000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_rec = 1'b0, key_play = 1'b0, key_stop = 1'b0;
    logic        cap = 1'b0, disp = 1'b0;
    logic [2:0]  o_state;
    logic [22:0] o_wr_base, o_rd_base;
    logic        o_wr_load, o_wr_en, o_rd_load;
    logic [3:0]  o_rec_count;
    logic [2:0]  o_play_slot;

    frame_seq_ctrl dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_key_rec          (key_rec),
        .i_key_play         (key_play),
        .i_key_stop         (key_stop),
        .i_cap_frame_start  (cap),
        .i_disp_frame_start (disp),
        .o_state            (o_state),
        .o_wr_base          (o_wr_base),
        .o_wr_load          (o_wr_load),
        .o_wr_en            (o_wr_en),
        .o_rd_base          (o_rd_base),
        .o_rd_load          (o_rd_load),
        .o_rec_count        (o_rec_count),
        .o_play_slot        (o_play_slot)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        en;
        logic [3:0]  cnt;
        logic [2:0]  ps;
        logic        wl;
        logic        rl;
    } exp_t;

    exp_t        exp_q[$];
    logic [22:0] wr_q[$];
    logic [22:0] rd_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: frames committed so far, playback slot and hold count.
    state_t m_state;
    int     m_total, m_play, m_hold;
    bit     m_en, m_recf;

    function automatic logic [22:0] addr(input int s);
        return 23'(s * 32'h40000);
    endfunction
    function automatic int m_cnt();
        return (m_total < N) ? m_total : N;
    endfunction
    function automatic int m_oldest();
        return (m_total >= N) ? (m_total % N) : 0;
    endfunction

    task automatic model_reset();
        m_state = LIVE; m_total = 0; m_play = 0; m_hold = 0; m_en = 0; m_recf = 0;
        exp_q.delete(); wr_q.delete(); rd_q.delete();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit p, input bit s, input bit c, input bit d);
        state_t ps      = m_state;
        int     pre_cnt = m_cnt();
        int     pre_old = m_oldest();
        int     newest  = (m_total + N - 1) % N;
        exp_t   e;
        bit     wl = 0, rl = 0;
        if (c) begin
            if (m_recf) m_total++;
            if (ps == LIVE) begin
                wl = 1; wr_q.push_back(LIVE_A); m_en = 1; m_recf = 0;
            end else if (ps == REC) begin
                wl = 1; wr_q.push_back(addr(m_total % N)); m_en = 1; m_recf = 1;
            end else begin
                m_en = 0; m_recf = 0;
            end
        end
        if (d) begin
            rl = 1;
            if (ps == PLAY || ps == PLAY_PAUSE) rd_q.push_back(addr(m_play));
            else rd_q.push_back(LIVE_A);
            if (ps == PLAY) begin
                if (m_hold == HOLD - 1) begin
                    m_hold = 0;
                    m_play = (m_play == newest) ? pre_old : (m_play + 1) % N;
                end else m_hold++;
            end
        end
        if (s) begin
            m_state = LIVE; m_en = 0; m_recf = 0;
        end else if (r) begin
            if (ps == LIVE || ps == REC_PAUSE) m_state = REC;
            else if (ps == REC) m_state = REC_PAUSE;
        end else if (p) begin
            if ((ps == LIVE || ps == REC_PAUSE) && pre_cnt > 0) begin
                m_state = PLAY; m_play = pre_old; m_hold = 0;
            end else if (ps == PLAY) m_state = PLAY_PAUSE;
            else if (ps == PLAY_PAUSE) m_state = PLAY;
        end
        e.st = m_state; e.en = m_en; e.cnt = 4'(m_cnt()); e.ps = 3'(m_play);
        e.wl = wl; e.rl = rl;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit p, input bit s, input bit c, input bit d);
        @(negedge clk);
        key_rec = r; key_play = p; key_stop = s; cap = c; disp = d;
        model(r, p, s, c, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_state", o_state, 3'd0);
        chk("rst_wr_base", o_wr_base, LIVE_A);
        chk("rst_rd_base", o_rd_base, LIVE_A);
        chk("rst_wr_load", o_wr_load, 0);
        chk("rst_rd_load", o_rd_load, 0);
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_rec_count", o_rec_count, 0);
        chk("rst_play_slot", o_play_slot, 0);
    endtask

    task automatic mid_reset();
        idle(1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 4) == 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", o_state, e.st);
            chk("wr_en", o_wr_en, e.en);
            chk("rec_count", o_rec_count, e.cnt);
            chk("play_slot", o_play_slot, e.ps);
            chk("wr_load", o_wr_load, e.wl);
            chk("rd_load", o_rd_load, e.rl);
            if (o_wr_load) begin
                if (wr_q.size() == 0) chk("wr_load_spurious", o_wr_load, 0);
                else chk("wr_base", o_wr_base, wr_q.pop_front());
            end
            if (o_rd_load) begin
                if (rd_q.size() == 0) chk("rd_load_spurious", o_rd_load, 0);
                else chk("rd_base", o_rd_base, rd_q.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check_reset_outputs();

        // live capture
        step(0, 0, 0, 1, 0); idle(3); step(0, 0, 0, 1, 0); idle(1);
        // record three frames, then fill the ring past capacity
        step(1, 0, 0, 0, 0); idle(1);
        for (int i = 0; i < 3; i++) begin step(0, 0, 0, 1, 0); idle(2); end
        for (int i = 0; i < 8; i++) begin step(0, 0, 0, 1, 0); idle(1); end
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 36; i++) begin step(0, 0, 0, 0, 1); idle(1); end
        // pause playback; display must hold on one slot
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin step(0, 0, 0, 0, 1); idle(1); end
        step(0, 0, 1, 0, 0); idle(2);

        // empty ring: play is ignored; stop discards an in-progress record frame
        mid_reset();
        step(0, 1, 0, 0, 0); idle(1);
        step(1, 0, 0, 0, 0); step(0, 0, 0, 1, 0); idle(1);
        step(0, 0, 0, 1, 0); idle(2);
        step(0, 0, 1, 0, 0); idle(1);
        step(0, 0, 0, 1, 0); idle(1);
        // simultaneous keys, then rec with a capture start in the same cycle
        step(1, 0, 0, 0, 0); step(0, 0, 0, 1, 0); idle(1);
        step(1, 1, 1, 0, 0); idle(1);
        step(1, 0, 0, 1, 0); idle(2);
        step(0, 0, 0, 1, 0); idle(2);

        random_run(3000);
        mid_reset();
        random_run(2000);
        idle(2);
        @(posedge clk);
        #3;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
